pacman_motion: RTL and testbench
================================

Name: pacman_motion

Overview:
- Pac-Man movement controller that consumes the 4-bit available-direction vector computed from the current position.
- It owns the player position registers PosX/PosY, buffers the player's requested turn, and advances the position once per frame tick.
- It handles the tunnel wrap and reports its facing direction for the sprite and pellet logic.
- It closes the loop: PosX/PosY feed the valid-move lookup, and availible_dir comes back from it combinationally.

Parameters:
- START_X, 221, reset/respawn X (col 13, lane-aligned: X%12=5)
- START_Y, 336, reset/respawn Y (row 23, lane-aligned: Y%12=0)
- SPEED, 1, pixels advanced per frame tick
- TUNNEL_Y, 228, Y of the wrap row
- X_MIN, 64, leftmost X in tunnel; stepping below wraps to X_MAX
- X_MAX, 392, rightmost X in tunnel; stepping above wraps to X_MIN
- REQ_HOLD, 16, frames a buffered turn request stays pending

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  VGA vsync-rate signal, asynchronous to Clk
- run  in  1  1 = motion enabled; 0 = freeze (death, level clear)
- respawn  in  1  synchronous pulse: restore start state
- keycode  in  8  USB keycode; W=0x1A, A=0x04, S=0x16, D=0x07
- availible_dir  in  4  bit0 left, bit1 up, bit2 right, bit3 down
- PosX  out  10  current X
- PosY  out  10  current Y
- dir  out  2  facing: 0 left, 1 up, 2 right, 3 down (indexes availible_dir)
- moving  out  1  1 if the last tick advanced position
- step  out  1  one-Clk pulse on every position update

Behaviour:
- Reset (async) state:
  - PosX=START_X, PosY=START_Y, dir=0 (left).
  - moving=0, step=0.
  - Request buffer empty; hold counter=0; sync flops=0.
- respawn: synchronous, same result as reset. It takes priority over everything else in that cycle.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then a rising-edge detect.
  - tick is a 1-Clk pulse, 3 Clk after the frame_clk rise at most.
- Request buffer:
  - Updated every Clk regardless of run.
  - A recognized keycode loads req_dir, sets req_valid and sets hold=REQ_HOLD.
  - An unrecognized keycode (including 0x00) leaves the buffer unchanged.
  - A newer key overwrites the pending one.
- States: IDLE (waiting for tick), EVAL (one cycle after tick), then return to IDLE.
  - Ticks arriving while run=0 are ignored.
  - In that case hold does not count and moving is cleared.
- EVAL, decided in priority order:
  1. Turn: if req_valid and availible_dir[req_dir]=1, then dir<=req_dir and req_valid<=0. Otherwise hold decrements; at 0, req_valid<=0.
  2. Tunnel: if PosY==TUNNEL_Y and the effective dir is left with PosX<X_MIN+SPEED, then PosX<=X_MAX. If the effective dir is right with PosX>X_MAX-SPEED, then PosX<=X_MIN. This applies regardless of availible_dir; moving=1, step=1.
  3. Advance: if availible_dir[effective dir]=1, PosX/PosY move SPEED pixels (left -X, up -Y, right +X, down +Y); moving=1, step=1.
  4. Blocked: hold position, moving=0, step=0. dir keeps its value so the sprite keeps facing the wall.
- Effective dir is the dir value after rule 1 is applied, in the same cycle.
- availible_dir is sampled in EVAL. It reflects PosX/PosY registered at least 1 cycle earlier, so it is stable.
- Reversal (request opposite to dir) is accepted on the next tick when that direction bit is set; no special case.
- Simultaneous keycode load and EVAL consumption: the load wins, and the new request stays pending.
- Arithmetic: 10-bit unsigned. Underflow cannot occur outside the tunnel because availible_dir forbids it.
- step is a single-cycle pulse, coincident with the PosX/PosY update.

Decomposition:
- Shared package pacman_pkg:
  - dir_t enum (LEFT=0, UP=1, RIGHT=2, DOWN=3)
  - keycode constants KEY_W/A/S/D
  - CELL=12 and grid offset constants, shared with valid_moves and the ghost controllers
- One sub-module: frame_tick_sync (2-flop synchronizer + rising-edge pulse), reusable by the ghost movers.

Test Plan:
- Reset: assert Reset mid-tick → PosX=221, PosY=336, dir=0, moving=0 immediately, with no Clk edge needed.
- Free run: availible_dir=4'b0001, run=1, 5 frame_clk pulses → PosX=216, PosY=336; 5 step pulses; moving=1.
- Buffered turn:
  - Setup: keycode=0x1A with availible_dir=4'b0001; after 3 ticks availible_dir=4'b0011.
  - Response: dir becomes 1 on that tick's EVAL, and PosY decreases from then on.
- Request expiry: keycode=0x07 once, right never available, REQ_HOLD=16 → req_valid clears after 16 ticks; setting bit2 on tick 17 causes no turn.
- Tunnel: PosY=228, PosX=64, dir=0, availible_dir=0 → next tick PosX=392, step=1; the mirror case (PosX=392, dir=2) → PosX=64.
- Freeze/blocked:
  - run=0 with 4 ticks → no position change, moving=0.
  - availible_dir=0 with run=1 → step never pulses, dir unchanged.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared maze-motion definitions: facing directions, USB keycodes and grid geometry.
// Used by the player controller, valid_moves and the ghost movers.
package pacman_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        UP    = 2'd1,
        RIGHT = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int CELL       = 12;
    localparam int GRID_X_OFF = 5;
    localparam int GRID_Y_OFF = 0;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dec_t;

    function automatic key_dec_t decodeKey(input logic [7:0] code);
        key_dec_t res;
        res.valid = 1'b1;
        res.dir   = LEFT;
        case (code)
            KEY_W:   res.dir = UP;
            KEY_A:   res.dir = LEFT;
            KEY_S:   res.dir = DOWN;
            KEY_D:   res.dir = RIGHT;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-rate frame clock into the system clock domain and emits a
// one-cycle tick on each of its rising edges.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic async_i,
    output logic tick_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else if (clear_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man movement controller: owns PosX/PosY, buffers turn requests and
// advances one step per frame tick, including the tunnel wrap.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter logic [9:0]  START_X  = 10'd221,
    parameter logic [9:0]  START_Y  = 10'd336,
    parameter logic [9:0]  SPEED    = 10'd1,
    parameter logic [9:0]  TUNNEL_Y = 10'd228,
    parameter logic [9:0]  X_MIN    = 10'd64,
    parameter logic [9:0]  X_MAX    = 10'd392,
    parameter int unsigned REQ_HOLD = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       run,
    input  logic       respawn,
    input  logic [7:0] keycode,
    input  logic [3:0] availible_dir,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] dir,
    output logic       moving,
    output logic       step
);

    localparam int HW = $clog2(REQ_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(REQ_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic {
        S_IDLE,
        S_EVAL
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    posX_q, posX_d;
    logic [9:0]    posY_q, posY_d;
    dir_t          dir_q, dir_d;
    logic          moving_q, moving_d;
    logic          step_q, step_d;
    dir_t          reqDir_q, reqDir_d;
    logic          reqValid_q, reqValid_d;
    logic [HW-1:0] hold_q, hold_d;

    logic     tick;
    key_dec_t key;
    dir_t     effDir;

    frame_tick_sync u_tick (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clear_i (respawn),
        .async_i (frame_clk),
        .tick_o  (tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            posX_q     <= START_X;
            posY_q     <= START_Y;
            dir_q      <= LEFT;
            moving_q   <= 1'b0;
            step_q     <= 1'b0;
            reqDir_q   <= LEFT;
            reqValid_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            posX_q     <= posX_d;
            posY_q     <= posY_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            step_q     <= step_d;
            reqDir_q   <= reqDir_d;
            reqValid_q <= reqValid_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        posX_d     = posX_q;
        posY_d     = posY_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        step_d     = 1'b0;
        reqDir_d   = reqDir_q;
        reqValid_d = reqValid_q;
        hold_d     = hold_q;
        effDir     = dir_q;
        key        = decodeKey(keycode);

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (run) state_d = S_EVAL;
                    else     moving_d = 1'b0;
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                if (reqValid_q && availible_dir[reqDir_q]) begin
                    dir_d      = reqDir_q;
                    effDir     = reqDir_q;
                    reqValid_d = 1'b0;
                end else if (reqValid_q) begin
                    hold_d = hold_q - HOLD_ONE;
                    if (hold_q <= HOLD_ONE) reqValid_d = 1'b0;
                end

                // The tunnel row wraps even though valid_moves reports it as closed.
                if (posY_q == TUNNEL_Y && effDir == LEFT && posX_q < X_MIN + SPEED) begin
                    posX_d   = X_MAX;
                    moving_d = 1'b1;
                    step_d   = 1'b1;
                end else if (posY_q == TUNNEL_Y && effDir == RIGHT && posX_q > X_MAX - SPEED) begin
                    posX_d   = X_MIN;
                    moving_d = 1'b1;
                    step_d   = 1'b1;
                end else if (availible_dir[effDir]) begin
                    case (effDir)
                        LEFT:    posX_d = posX_q - SPEED;
                        UP:      posY_d = posY_q - SPEED;
                        RIGHT:   posX_d = posX_q + SPEED;
                        default: posY_d = posY_q + SPEED;
                    endcase
                    moving_d = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    moving_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh keypress beats a same-cycle consumption so it stays pending.
        if (key.valid) begin
            reqDir_d   = key.dir;
            reqValid_d = 1'b1;
            hold_d     = HOLD_INIT;
        end

        if (respawn) begin
            state_d    = S_IDLE;
            posX_d     = START_X;
            posY_d     = START_Y;
            dir_d      = LEFT;
            moving_d   = 1'b0;
            step_d     = 1'b0;
            reqDir_d   = LEFT;
            reqValid_d = 1'b0;
            hold_d     = '0;
        end
    end

    assign PosX   = posX_q;
    assign PosY   = posY_q;
    assign dir    = dir_q;
    assign moving = moving_q;
    assign step   = step_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Scoreboard bench for pacman_motion: directed ticks push expected positions,
// a monitor pops one entry per step pulse.
module tb_pacman_motion;
    import pacman_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       run;
    logic       respawn;
    logic [7:0] keycode;
    logic [3:0] availible_dir;
    logic [9:0] PosX, PosY;
    logic [1:0] dir;
    logic       moving, step;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] d;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         checks = 0;
    int         failures = 0;
    int         stepCount = 0;
    int         savedSteps;
    logic [9:0] ex, ey;
    logic [1:0] ed;

    pacman_motion dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .run           (run),
        .respawn       (respawn),
        .keycode       (keycode),
        .availible_dir (availible_dir),
        .PosX          (PosX),
        .PosY          (PosY),
        .dir           (dir),
        .moving        (moving),
        .step          (step)
    );

    always #5 Clk = ~Clk;

    // Every step pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Reset === 1'b0 && step === 1'b1) begin
            stepCount++;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_step: got step at X=%0d Y=%0d dir=%0d, required no step",
                         PosX, PosY, dir);
            end else begin
                monE = expQ.pop_front();
                if (PosX !== monE.x || PosY !== monE.y || dir !== monE.d) begin
                    failures++;
                    $display("[TB] FAIL step_pos: got X=%0d Y=%0d dir=%0d, required X=%0d Y=%0d dir=%0d",
                             PosX, PosY, dir, monE.x, monE.y, monE.d);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic frameTick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pressKey(input logic [7:0] k);
        @(negedge Clk) keycode = k;
        @(negedge Clk) keycode = 8'h00;
    endtask

    // One tick that must step to exactly (x, y) facing d.
    task automatic applyStimulus(input logic [3:0] av, input logic [9:0] x, input logic [9:0] y,
                                 input logic [1:0] d);
        availible_dir = av;
        ex = x;
        ey = y;
        ed = d;
        expQ.push_back('{x: x, y: y, d: d});
        frameTick();
    endtask

    task automatic tickRun(input logic [3:0] av, input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            case (d)
                2'd0:    applyStimulus(av, ex - 10'd1, ey, d);
                2'd1:    applyStimulus(av, ex, ey - 10'd1, d);
                2'd2:    applyStimulus(av, ex + 10'd1, ey, d);
                default: applyStimulus(av, ex, ey + 10'd1, d);
            endcase
        end
    endtask

    task automatic tickIdle(input logic [3:0] av, input int n);
        availible_dir = av;
        for (int i = 0; i < n; i++) frameTick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        run = 1'b1;
        respawn = 1'b0;
        keycode = 8'h00;
        availible_dir = 4'b0000;
        ex = 10'd221;
        ey = 10'd336;
        ed = 2'd0;
        repeat (3) @(negedge Clk);
        checkOutput("reset_x", PosX, 221);
        checkOutput("reset_y", PosY, 336);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_moving", moving, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        $display("[TB] free run left");
        tickRun(4'b0001, 2'd0, 5);
        checkOutput("free_x", PosX, 216);
        checkOutput("free_y", PosY, 336);
        checkOutput("free_moving", moving, 1);
        checkOutput("free_steps", stepCount, 5);

        $display("[TB] async reset mid-tick");
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checkOutput("midreset_x", PosX, 221);
        checkOutput("midreset_y", PosY, 336);
        checkOutput("midreset_dir", dir, 0);
        checkOutput("midreset_moving", moving, 0);
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        ex = 10'd221;
        ey = 10'd336;
        repeat (2) @(negedge Clk);

        $display("[TB] buffered turn");
        pressKey(KEY_W);
        tickRun(4'b0001, 2'd0, 3);
        checkOutput("turn_wait_dir", dir, 0);
        tickRun(4'b0011, 2'd1, 2);
        checkOutput("turn_dir", dir, 1);
        checkOutput("turn_y", PosY, 334);

        $display("[TB] request expiry");
        pressKey(KEY_D);
        tickRun(4'b0010, 2'd1, 16);
        tickRun(4'b0110, 2'd1, 1);
        checkOutput("expiry_dir", dir, 1);
        checkOutput("expiry_x", PosX, 218);

        $display("[TB] request accepted on last hold tick");
        pressKey(KEY_D);
        tickRun(4'b0010, 2'd1, 15);
        tickRun(4'b0110, 2'd2, 1);
        checkOutput("lasthold_dir", dir, 2);
        pressKey(KEY_W);
        tickRun(4'b0010, 2'd1, 74);
        checkOutput("tunnel_row_y", PosY, 228);

        pressKey(KEY_A);
        tickRun(4'b0001, 2'd0, 155);
        checkOutput("tunnel_edge_x", PosX, 64);

        $display("[TB] tunnel wrap");
        applyStimulus(4'b0000, 10'd392, 10'd228, 2'd0);
        checkOutput("wrap_left_x", PosX, 392);
        pressKey(KEY_D);
        applyStimulus(4'b0100, 10'd64, 10'd228, 2'd2);
        checkOutput("wrap_right_x", PosX, 64);
        checkOutput("wrap_right_dir", dir, 2);

        $display("[TB] blocked");
        applyStimulus(4'b0100, 10'd65, 10'd228, 2'd2);
        savedSteps = stepCount;
        tickIdle(4'b0000, 3);
        checkOutput("blocked_steps", stepCount, savedSteps);
        checkOutput("blocked_x", PosX, 65);
        checkOutput("blocked_dir", dir, 2);
        checkOutput("blocked_moving", moving, 0);

        $display("[TB] freeze");
        applyStimulus(4'b0100, 10'd66, 10'd228, 2'd2);
        checkOutput("prefreeze_moving", moving, 1);
        run = 1'b0;
        savedSteps = stepCount;
        tickIdle(4'b0100, 4);
        checkOutput("freeze_steps", stepCount, savedSteps);
        checkOutput("freeze_x", PosX, 66);
        checkOutput("freeze_moving", moving, 0);
        run = 1'b1;

        $display("[TB] respawn");
        @(negedge Clk) respawn = 1'b1;
        @(negedge Clk) respawn = 1'b0;
        checkOutput("respawn_x", PosX, 221);
        checkOutput("respawn_y", PosY, 336);
        checkOutput("respawn_dir", dir, 0);
        checkOutput("respawn_moving", moving, 0);

        repeat (4) @(negedge Clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
